// File: rtl/sift_core.sv
// sift_core: streaming 3x3 Gaussian blur over a raster-order pixel stream.
// Two line buffers supply the rows above the incoming pixel, and a 3x3
// register window slides along the current row.  Interior pixels produce
// one registered output each.
// Optional feature: define SIFT_CORE_DOG_EN to place the saturated
// difference-of-Gaussian (blurred - original) on out_data[15:8].
// Note: rst_n is an active-HIGH synchronous reset despite its name.
module sift_core #(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        out_valid,
    output logic [15:0] out_data
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_lb0 [COLS];   // row r-1
    logic [7:0]    r_lb1 [COLS];   // row r-2
    logic [7:0]    r_win [3][3];   // [row][col]; row 0 = oldest row, col 0 = oldest column

    logic [7:0]  w_px;
    logic [7:0]  w_up1;
    logic [7:0]  w_up2;
    logic [7:0]  w_win_n [3][3];
    logic [11:0] w_sum;
    logic [11:0] w_rnd;
    logic [7:0]  w_blur;
    logic [7:0]  w_dog;
    logic        w_fire;
    logic        w_accept;
    logic        w_unused;

    assign w_px     = in_data[7:0];
    assign w_unused = ^in_data[15:8];
    assign w_up1    = r_lb0[r_col];
    assign w_up2    = r_lb1[r_col];
    assign w_accept = in_valid && !rst_n;
    // A window is complete only once it holds three columns of this row and
    // three rows of this frame, so it never straddles a row or frame wrap.
    assign w_fire   = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));

    // Window as it will look after the current pixel is shifted in.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        for (int i = 0; i < 3; i++) begin
            w_win_n[i][0] = r_win[i][1];
            w_win_n[i][1] = r_win[i][2];
            w_win_n[i][2] = 8'd0;
        end
        w_win_n[0][2] = w_up2;
        w_win_n[1][2] = w_up1;
        w_win_n[2][2] = w_px;
    end

    // Gaussian [1 2 1; 2 4 2; 1 2 1]; max 16*255 = 4080, rounding stays within 12 bits.
    always_comb begin
        w_sum = 12'(w_win_n[0][0]) + 12'(w_win_n[0][2])
              + 12'(w_win_n[2][0]) + 12'(w_win_n[2][2])
              + (12'(w_win_n[0][1]) << 1) + (12'(w_win_n[1][0]) << 1)
              + (12'(w_win_n[1][2]) << 1) + (12'(w_win_n[2][1]) << 1)
              + (12'(w_win_n[1][1]) << 2);
        w_rnd  = w_sum + 12'd8;
        w_blur = w_rnd[11:4];
    end

`ifdef SIFT_CORE_DOG_EN
    logic signed [8:0] w_diff;

    // Blurred minus original centre pixel, saturated to a signed byte.
    always_comb begin
        w_diff = $signed({1'b0, w_blur}) - $signed({1'b0, w_win_n[1][1]});
        if (w_diff > 9'sd127)
            w_dog = 8'h7F;
        else if (w_diff < -9'sd128)
            w_dog = 8'h80;
        else
            w_dog = w_diff[7:0];
    end
`else
    assign w_dog = 8'd0;
`endif

    // Raster position of the next pixel to arrive.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffers: push the column down one row and store the new pixel.
    always_ff @(posedge clk) begin
        // NOTE: line buffers are RAM-like and deliberately not reset; stale
        // contents are never used because outputs wait for rows 0 and 1.
        if (w_accept) begin
            r_lb1[r_col] <= w_up1;
            r_lb0[r_col] <= w_px;
        end
    end

    // Sliding 3x3 window.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_win[i][j] <= 8'd0;
        end else if (in_valid) begin
            r_win <= w_win_n;
        end
    end

    // Registered output; data holds between valid pulses.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 16'd0;
        end else begin
            out_valid <= w_fire;
            if (w_fire)
                out_data <= {w_dog, w_blur};
        end
    end

endmodule

// File: tb/tb_sift_core.sv
// tb_sift_core: directed bench for sift_core on a small 12x10 image.
// Define SIFT_CORE_DOG_EN for both files to check the DoG byte.
module tb_sift_core;

    localparam int COLS = 12;
    localparam int ROWS = 10;
    localparam int NOUT = (ROWS - 2) * (COLS - 2);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;

    sift_core #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         r;
        int         c;
        logic [7:0] lo;
        logic [7:0] dog;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int br = 0, bc = 0;              // bench's own raster position
    int n_out, tot_out = 0;
    int timing_err, hold_err;
    logic [15:0] last_data = 16'd0;
    logic [7:0]  cap_lo [ROWS][COLS];
    logic [7:0]  cap_hi [ROWS][COLS];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, predict out_valid from the bench position,
    // then sample outputs on the falling edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic rst);
        logic exp_v;
        in_valid = v;
        in_data  = {8'hA5, d};
        rst_n    = rst;
        @(posedge clk);
        exp_v = v && !rst && br >= 2 && bc >= 2;
        if (rst) begin
            br = 0;
            bc = 0;
        end else if (v) begin
            bc++;
            if (bc == COLS) begin
                bc = 0;
                br++;
                if (br == ROWS) br = 0;
            end
        end
        @(negedge clk);
        if (out_valid !== exp_v) timing_err++;
        if (rst) begin
            last_data = 16'd0;
        end else if (out_valid === 1'b1) begin
            if (n_out < NOUT) begin
                cap_lo[n_out / (COLS - 2) + 1][n_out % (COLS - 2) + 1] = out_data[7:0];
                cap_hi[n_out / (COLS - 2) + 1][n_out % (COLS - 2) + 1] = out_data[15:8];
            end
            n_out++;
            tot_out++;
            last_data = out_data;
        end else if (out_data !== last_data) begin
            hold_err++;
        end
    endtask

    function automatic logic [7:0] pix(input int kind, input int v, input int r, input int c);
        if (kind == 1) return (r == 5 && c == 5) ? 8'd255 : 8'd0;
        return v[7:0];
    endfunction

    // Drive one full frame; stall inserts the 1,0,0 in_valid pattern.
    task automatic run_frame(input int kind, input int v, input bit stall);
        n_out = 0;
        timing_err = 0;
        hold_err = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                cap_lo[r][c] = 8'hEE;
                cap_hi[r][c] = 8'hEE;
            end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                cycle(1'b1, pix(kind, v, r, c), 1'b0);
                if (stall) begin
                    cycle(1'b0, 8'h5A, 1'b0);
                    cycle(1'b0, 8'hC3, 1'b0);
                end
            end
    endtask

    task automatic frame_checks(input string name);
        check({name, " count"}, n_out, NOUT);
        check({name, " timing"}, timing_err, 0);
        check({name, " hold"}, hold_err, 0);
    endtask

    task automatic const_checks(input string name, input int v);
        int bad = 0;
        for (int r = 1; r < ROWS - 1; r++)
            for (int c = 1; c < COLS - 1; c++)
                if (cap_lo[r][c] !== v[7:0] || cap_hi[r][c] !== 8'd0) bad++;
        check({name, " values"}, bad, 0);
    endtask

    task automatic impulse_checks(input string name);
        vec_t tbl [11];
        int   bad = 0;
        logic [7:0] exp_hi;
        tbl[0]  = '{5, 5, 8'd64, 8'h80};
        tbl[1]  = '{4, 5, 8'd32, 8'h20};
        tbl[2]  = '{5, 4, 8'd32, 8'h20};
        tbl[3]  = '{6, 5, 8'd32, 8'h20};
        tbl[4]  = '{5, 6, 8'd32, 8'h20};
        tbl[5]  = '{4, 4, 8'd16, 8'h10};
        tbl[6]  = '{6, 6, 8'd16, 8'h10};
        tbl[7]  = '{4, 6, 8'd16, 8'h10};
        tbl[8]  = '{6, 4, 8'd16, 8'h10};
        tbl[9]  = '{8, 8, 8'd0,  8'h00};
        tbl[10] = '{1, 1, 8'd0,  8'h00};
        for (int i = 0; i < 11; i++) begin
`ifdef SIFT_CORE_DOG_EN
            exp_hi = tbl[i].dog;
`else
            exp_hi = 8'd0;
`endif
            check($sformatf("%s blur(%0d,%0d)", name, tbl[i].r, tbl[i].c),
                  int'(cap_lo[tbl[i].r][tbl[i].c]), int'(tbl[i].lo));
            check($sformatf("%s dog(%0d,%0d)", name, tbl[i].r, tbl[i].c),
                  int'(cap_hi[tbl[i].r][tbl[i].c]), int'(exp_hi));
        end
        for (int r = 1; r < ROWS - 1; r++)
            for (int c = 1; c < COLS - 1; c++)
                if ((r < 4 || r > 6 || c < 4 || c > 6) &&
                    (cap_lo[r][c] !== 8'd0 || cap_hi[r][c] !== 8'd0)) bad++;
        check({name, " far zeros"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_data = 16'd0;
        timing_err = 0;
        hold_err = 0;
        n_out = 0;

        // Reset with in_valid high: pixels must be dropped.
        cycle(1'b1, 8'd77, 1'b1);
        cycle(1'b1, 8'd77, 1'b1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);

        run_frame(0, 100, 1'b0);
        frame_checks("const100");
        const_checks("const100", 100);

        run_frame(1, 0, 1'b0);
        frame_checks("impulse");
        impulse_checks("impulse");

        run_frame(1, 0, 1'b1);
        frame_checks("impulse stall");
        impulse_checks("impulse stall");

        // Mid-frame abort: partial frame of 200s, reset, then constant 50.
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'd200, 1'b0);
        check("pre-abort data", int'(out_data[7:0]), 200);
        cycle(1'b1, 8'd200, 1'b1);
        check("abort out_valid", int'(out_valid), 0);
        check("abort out_data", int'(out_data), 0);
        run_frame(0, 50, 1'b0);
        frame_checks("abort const50");
        const_checks("abort const50", 50);

        // Two back-to-back all-255 frames.
        tot_out = 0;
        run_frame(0, 255, 1'b0);
        frame_checks("white1");
        const_checks("white1", 255);
        run_frame(0, 255, 1'b0);
        frame_checks("white2");
        const_checks("white2", 255);
        check("white total", tot_out, 2 * NOUT);

        // Idle stall keeps out_valid low and data held.
        timing_err = 0;
        hold_err = 0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'd9, 1'b0);
        check("idle timing", timing_err, 0);
        check("idle hold", hold_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
